mul_fifo_param: RTL
===================

Name: mul_fifo_param

Overview:
- Parametrised synchronous FIFO with integrated operation state machine, pointer/count registers and storage array.
- Next generation of the team's fixed 8-entry FIFO calculator, generalised in data width and depth.
- Adds a simultaneous read+write operation, registered ack/error pulses and registered read data.
- Sits between the multiplier result stage and the downstream consumer.

Parameters:
- DATA_W, 8, data word width in bits.
- ADDR_W, 3, pointer width; DEPTH = 2**ADDR_W entries.
- AF_LEVEL, DEPTH-2, almost-full threshold (used only with the optional feature).
- AE_LEVEL, 1, almost-empty threshold (used only with the optional feature).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- wr_en  in  1  write request, sampled at rising edge.
- rd_en  in  1  read request, sampled at rising edge.
- din  in  DATA_W  write data.
- dout  out  DATA_W  registered read data.
- state  out  3  current operation state.
- data_count  out  ADDR_W+1  number of occupied entries.
- full  out  1  data_count == DEPTH.
- empty  out  1  data_count == 0.
- wr_ack  out  1  one-cycle pulse: write accepted.
- wr_err  out  1  one-cycle pulse: write rejected because full.
- rd_ack  out  1  one-cycle pulse: read accepted; dout valid.
- rd_err  out  1  one-cycle pulse: read rejected because empty.
- almost_full  out  1  optional level flag.
- almost_empty  out  1  optional level flag.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - head, tail, data_count, dout, wr_ack, wr_err, rd_ack, rd_err = 0.
  - state = INIT.
  - Storage array is not cleared.
- State encoding: INIT 000, NO_OP 001, WRITE 010, WR_ERROR 011, READ 100, RD_ERROR 101, RD_WR 110. Code 111 is unused and recovers to NO_OP.
- State transitions, evaluated at each rising edge from the sampled wr_en, rd_en and the current full/empty (valid from INIT and every other state):
  - no request -> NO_OP.
  - wr only, !full -> WRITE: mem[tail]=din; tail+1; count+1.
  - wr only, full -> WR_ERROR: no change.
  - rd only, !empty -> READ: dout=mem[head]; head+1; count-1.
  - rd only, empty -> RD_ERROR: no change.
  - wr and rd, !empty (including full) -> RD_WR: write at tail, read head to dout, both pointers +1, count unchanged. A full FIFO accepts the write because the read frees a slot in the same cycle.
  - wr and rd, empty -> WRITE: write accepted, read rejected, rd_err=1.
- Pulses: registered, high for exactly the cycle following the accepting/rejecting edge; they coincide with the state value of that operation.
- Read latency: dout updates on the accepting edge; it is valid while rd_ack=1 and holds its value until the next accepted read.
- Pointers wrap modulo DEPTH (natural ADDR_W overflow). data_count never exceeds DEPTH and never underflows.
- full and empty are decoded combinationally from the data_count register only (no input-to-output paths).

Optional Feature:
- Macro: MUL_FIFO_LEVEL_FLAGS_EN.
- Defined:
  - almost_full = (data_count >= AF_LEVEL).
  - almost_empty = (data_count <= AE_LEVEL).
  - Both decoded from the count register; each reads 0 for AF_LEVEL/1 for AE_LEVEL respectively after reset (almost_empty=1 after reset).
- Undefined: both ports tied to 0; the threshold parameters are ignored.

Decomposition:
- Package mul_fifo_pkg:
  - 3-bit state typedef and the seven state constants.
  - Helper function for DEPTH from ADDR_W.
- Sub-module mul_fifo_ns_cal:
  - Purely combinational.
  - Inputs: state, requests, full, empty, head, tail, data_count.
  - Outputs: next_state, next_head, next_tail, next_data_count, memory write enable, read enable.
- The top level holds all registers, the storage array and the pulse/flag logic.

Test Plan:
- Reset, then 8 writes of 0x11..0x88 -> wr_ack on each; data_count=8; full=1; state=WRITE.
- 9th write while full -> state=WR_ERROR, wr_err=1 for one cycle, count stays 8, tail unchanged.
- 8 reads -> dout sequence 0x11..0x88 with rd_ack on each; empty=1. Extra read -> RD_ERROR, rd_err=1, dout holds 0x88.
- Simultaneous wr+rd at full (count=8), din=0x99 -> state=RD_WR, dout=oldest entry, count stays 8, wr_ack=rd_ack=1.
- Simultaneous wr+rd at empty, din=0x5A -> state=WRITE, wr_ack=1, rd_err=1, count=1. The next read returns 0x5A.
- 20 write/read pairs to exercise pointer wrap, then assert reset mid-stream -> count=0, state=INIT, all pulses 0 immediately. With MUL_FIFO_LEVEL_FLAGS_EN defined: almost_full rises at count 6, almost_empty=1 at count ≤1.

Source files
------------

// File: rtl/mul_fifo_pkg.sv
// Shared types and helpers for the parametrised multiplier-result FIFO.
package mul_fifo_pkg;

    typedef enum logic [2:0] {
        ST_INIT     = 3'b000,
        ST_NO_OP    = 3'b001,
        ST_WRITE    = 3'b010,
        ST_WR_ERROR = 3'b011,
        ST_READ     = 3'b100,
        ST_RD_ERROR = 3'b101,
        ST_RD_WR    = 3'b110
    } state_t;

    // 3'b111 is never produced; if it ever appears the FSM falls back to NO_OP.
    localparam logic [2:0] ST_UNUSED_CODE = 3'b111;

    function automatic int fifo_depth(input int addr_w);
        return 32'sd1 << addr_w;
    endfunction

endpackage

// File: rtl/mul_fifo_ns_cal.sv
// Combinational next-state, pointer and count calculation for mul_fifo_param.
module mul_fifo_ns_cal
    import mul_fifo_pkg::*;
#(
    parameter int ADDR_W = 3
) (
    input  state_t            state_i,
    input  logic              wr_en_i,
    input  logic              rd_en_i,
    input  logic              full_i,
    input  logic              empty_i,
    input  logic [ADDR_W-1:0] head_i,
    input  logic [ADDR_W-1:0] tail_i,
    input  logic [ADDR_W:0]   count_i,
    output state_t            next_state_o,
    output logic [ADDR_W-1:0] next_head_o,
    output logic [ADDR_W-1:0] next_tail_o,
    output logic [ADDR_W:0]   next_count_o,
    output logic              mem_we_o,
    output logic              mem_re_o
);

    localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    // Decode the sampled requests against the current fill level.
    always_comb begin
        next_state_o = ST_NO_OP;
        next_head_o  = head_i;
        next_tail_o  = tail_i;
        next_count_o = count_i;
        mem_we_o     = 1'b0;
        mem_re_o     = 1'b0;
        if (state_i == ST_UNUSED_CODE) begin
            next_state_o = ST_NO_OP;
        end else begin
            case ({wr_en_i, rd_en_i})
                2'b00: begin
                    next_state_o = ST_NO_OP;
                end
                2'b10: begin
                    if (!full_i) begin
                        next_state_o = ST_WRITE;
                        mem_we_o     = 1'b1;
                        next_tail_o  = tail_i + PTR_ONE;
                        next_count_o = count_i + CNT_ONE;
                    end else begin
                        next_state_o = ST_WR_ERROR;
                    end
                end
                2'b01: begin
                    if (!empty_i) begin
                        next_state_o = ST_READ;
                        mem_re_o     = 1'b1;
                        next_head_o  = head_i + PTR_ONE;
                        next_count_o = count_i - CNT_ONE;
                    end else begin
                        next_state_o = ST_RD_ERROR;
                    end
                end
                2'b11: begin
                    // A full FIFO still takes the write: the read frees a slot.
                    if (!empty_i) begin
                        next_state_o = ST_RD_WR;
                        mem_we_o     = 1'b1;
                        mem_re_o     = 1'b1;
                        next_head_o  = head_i + PTR_ONE;
                        next_tail_o  = tail_i + PTR_ONE;
                    end else begin
                        next_state_o = ST_WRITE;
                        mem_we_o     = 1'b1;
                        next_tail_o  = tail_i + PTR_ONE;
                        next_count_o = count_i + CNT_ONE;
                    end
                end
                default: begin
                    next_state_o = ST_NO_OP;
                end
            endcase
        end
    end

endmodule

// File: rtl/mul_fifo_param.sv
// Parametrised FIFO with operation FSM, registered read data and ack/error pulses.
// Level flags almost_full/almost_empty are built only with MUL_FIFO_LEVEL_FLAGS_EN.
module mul_fifo_param
    import mul_fifo_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int AF_LEVEL = fifo_depth(ADDR_W) - 2,
    parameter int AE_LEVEL = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic [2:0]        state,
    output logic [ADDR_W:0]   data_count,
    output logic              full,
    output logic              empty,
    output logic              wr_ack,
    output logic              wr_err,
    output logic              rd_ack,
    output logic              rd_err,
    output logic              almost_full,
    output logic              almost_empty
);

    localparam int            DEPTH     = fifo_depth(ADDR_W);
    localparam logic [ADDR_W:0] DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   head_q, head_d;
    logic [ADDR_W-1:0]   tail_q, tail_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic                wr_ack_q, wr_ack_d;
    logic                wr_err_q, wr_err_d;
    logic                rd_ack_q, rd_ack_d;
    logic                rd_err_q, rd_err_d;
    logic                mem_we_s, mem_re_s;
    logic                full_s, empty_s;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    assign full_s  = (count_q == DEPTH_CNT);
    assign empty_s = (count_q == {(ADDR_W+1){1'b0}});

    mul_fifo_ns_cal #(
        .ADDR_W (ADDR_W)
    ) u_ns_cal (
        .state_i      (state_q),
        .wr_en_i      (wr_en),
        .rd_en_i      (rd_en),
        .full_i       (full_s),
        .empty_i      (empty_s),
        .head_i       (head_q),
        .tail_i       (tail_q),
        .count_i      (count_q),
        .next_state_o (state_d),
        .next_head_o  (head_d),
        .next_tail_o  (tail_d),
        .next_count_o (count_d),
        .mem_we_o     (mem_we_s),
        .mem_re_o     (mem_re_s)
    );

    // Pulse and read-data next values; a wr+rd on empty writes but flags the read.
    always_comb begin
        wr_ack_d = mem_we_s;
        rd_ack_d = mem_re_s;
        wr_err_d = (state_d == ST_WR_ERROR);
        rd_err_d = (state_d == ST_RD_ERROR) || (rd_en && mem_we_s && !mem_re_s);
        if (mem_re_s) begin
            dout_d = mem_q[head_q];
        end else begin
            dout_d = dout_q;
        end
    end

    // Control, pointer, count, read-data and pulse registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_INIT;
            head_q   <= {ADDR_W{1'b0}};
            tail_q   <= {ADDR_W{1'b0}};
            count_q  <= {(ADDR_W+1){1'b0}};
            dout_q   <= {DATA_W{1'b0}};
            wr_ack_q <= 1'b0;
            wr_err_q <= 1'b0;
            rd_ack_q <= 1'b0;
            rd_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            wr_ack_q <= wr_ack_d;
            wr_err_q <= wr_err_d;
            rd_ack_q <= rd_ack_d;
            rd_err_q <= rd_err_d;
        end
    end

    // Storage array; deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[tail_q] <= din;
        end
    end

`ifdef MUL_FIFO_LEVEL_FLAGS_EN
    localparam logic [ADDR_W:0] AF_CNT = AF_LEVEL[ADDR_W:0];
    localparam logic [ADDR_W:0] AE_CNT = AE_LEVEL[ADDR_W:0];
    assign almost_full  = (count_q >= AF_CNT);
    assign almost_empty = (count_q <= AE_CNT);
`else
    assign almost_full  = 1'b0;
    assign almost_empty = 1'b0;
`endif

    assign dout       = dout_q;
    assign state      = state_q;
    assign data_count = count_q;
    assign full       = full_s;
    assign empty      = empty_s;
    assign wr_ack     = wr_ack_q;
    assign wr_err     = wr_err_q;
    assign rd_ack     = rd_ack_q;
    assign rd_err     = rd_err_q;

endmodule
